bitty_bus_xbar: RTL

- Parametrised 2-master x NUM_SLV-slave crossbar for the bitty RISC-V SoC top.
- Replaces the fixed point-to-point wiring of core fetch to ROM and core load/store to RAM.
- Master 0 is the core data port; master 1 is the core instruction port. Both ports use req/gnt/rvalid handshakes.
- Slaves are synchronous-read memories or peripherals with 1-cycle read latency. Each slave has ce/we/sel/addr/wdata inputs and an rdata output.

---
 rtl/bitty_bus_xbar.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/bitty_bus_xbar.sv
`timescale 1ns/1ps
// bitty_bus_xbar
// Two-master by NUM_SLV-slave crossbar for the bitty RISC-V SoC.
// Master 0 is the core data port and master 1 the core instruction port.
// Slaves are synchronous-read memories or peripherals with one cycle of read latency.
//
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   m_req/m_we      : per-master request and write enable (bit i = master i)
//   m_addr/m_sel    : per-master address and byte select, packed master-major
//   m_wdata         : per-master write data
//   m_gnt           : combinational grant in the request cycle
//   m_rvalid        : response valid one cycle after each grant
//   m_rdata/m_err   : response data and decode-error flag, qualified by m_rvalid
//   s_ce/s_we       : per-slave chip enable and write enable
//   s_addr/s_sel    : per-slave forwarded address and byte select
//   s_wdata/s_rdata : per-slave write data and read data
//   stat_conflicts  : number of conflict cycles (saturating)
//   stat_forced     : number of starvation-forced master-1 wins (saturating)
//
// Optional feature: define BITTY_BUS_STATS_EN to build the statistics
// counters; without it both stat outputs are tied to zero.

module bitty_bus_xbar #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int NUM_SLV   = 4,
  parameter int SEL_W     = 2,
  parameter int MAX_STALL = 4,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    m_req,
  input  logic [1:0]                    m_we,
  input  logic [2*ADDR_W-1:0]           m_addr,
  input  logic [2*(DATA_W/8)-1:0]       m_sel,
  input  logic [2*DATA_W-1:0]           m_wdata,
  output logic [1:0]                    m_gnt,
  output logic [1:0]                    m_rvalid,
  output logic [2*DATA_W-1:0]           m_rdata,
  output logic [1:0]                    m_err,
  output logic [NUM_SLV-1:0]            s_ce,
  output logic [NUM_SLV-1:0]            s_we,
  output logic [NUM_SLV*ADDR_W-1:0]     s_addr,
  output logic [NUM_SLV*(DATA_W/8)-1:0] s_sel,
  output logic [NUM_SLV*DATA_W-1:0]     s_wdata,
  input  logic [NUM_SLV*DATA_W-1:0]     s_rdata,
  output logic [15:0]                   stat_conflicts,
  output logic [15:0]                   stat_forced
);

  localparam int BW = DATA_W / 8;
  localparam logic [SEL_W:0] NUM_SLV_C  = NUM_SLV[SEL_W:0];
  localparam logic [3:0]     MAX_STALL_C = 4'(MAX_STALL);

  logic [SEL_W-1:0] idx [2];
  logic [1:0]       dec_err;
  logic             conflict;
  logic             force_m1;
  logic [3:0]       stall_cnt;

  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_err;
  logic [1:0]       rsp_we;
  logic [SEL_W-1:0] rsp_idx [2];

  // Slave index is the top SEL_W address bits; indices past the last slave are decode errors.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      idx[i]     = m_addr[i*ADDR_W + ADDR_W - 1 -: SEL_W];
      dec_err[i] = ({1'b0, idx[i]} >= NUM_SLV_C);
    end
  end

  // A conflict needs two valid decodes to the same slave; decode errors never collide.
  assign conflict = m_req[0] & m_req[1] & ~dec_err[0] & ~dec_err[1] & (idx[0] == idx[1]);
  assign force_m1 = conflict & (stall_cnt == MAX_STALL_C);

  assign m_gnt[0] = ~rst & m_req[0] & ~force_m1;
  assign m_gnt[1] = ~rst & m_req[1] & (~conflict | force_m1);

  // Only one master can be granted per slave, so the first match is the only match.
  always_comb begin
    s_ce    = '0;
    s_we    = '0;
    s_addr  = '0;
    s_sel   = '0;
    s_wdata = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (m_gnt[i] && !dec_err[i] && (idx[i] == SEL_W'(k))) begin
          s_ce[k]                      = 1'b1;
          s_we[k]                      = m_we[i];
          s_addr[k*ADDR_W +: ADDR_W]   = m_addr[i*ADDR_W +: ADDR_W];
          s_sel[k*BW +: BW]            = m_sel[i*BW +: BW];
          s_wdata[k*DATA_W +: DATA_W]  = m_wdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Starvation counter: grows on each conflict master 1 loses, clears when it wins or goes idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!m_req[1] || m_gnt[1]) begin
      stall_cnt <= '0;
    end else if (conflict) begin
      stall_cnt <= stall_cnt + 4'd1;
    end
  end

  // Route state remembers where each granted request went so the response can be steered back.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= '0;
      rsp_err    <= '0;
      rsp_we     <= '0;
      rsp_idx[0] <= '0;
      rsp_idx[1] <= '0;
    end else begin
      rsp_valid  <= m_gnt;
      rsp_err    <= dec_err;
      rsp_we     <= m_we;
      rsp_idx[0] <= idx[0];
      rsp_idx[1] <= idx[1];
    end
  end

  // Responses are masked during reset so a response due in the reset cycle is dropped.
  always_comb begin
    m_rvalid = rsp_valid & {2{~rst}};
    m_err    = m_rvalid & rsp_err;
    m_rdata  = '0;
    for (int i = 0; i < 2; i++) begin
      if (m_rvalid[i]) begin
        if (rsp_err[i]) begin
          m_rdata[i*DATA_W +: DATA_W] = ERR_DATA;
        end else if (!rsp_we[i]) begin
          for (int k = 0; k < NUM_SLV; k++) begin
            if (rsp_idx[i] == SEL_W'(k)) begin
              m_rdata[i*DATA_W +: DATA_W] = s_rdata[k*DATA_W +: DATA_W];
            end
          end
        end
      end
    end
  end

`ifdef BITTY_BUS_STATS_EN
  logic [15:0] conf_q;
  logic [15:0] forced_q;

  // Saturating event counters for arbitration statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      conf_q   <= '0;
      forced_q <= '0;
    end else begin
      if (conflict && (conf_q != 16'hFFFF)) begin
        conf_q <= conf_q + 16'd1;
      end
      if (force_m1 && (forced_q != 16'hFFFF)) begin
        forced_q <= forced_q + 16'd1;
      end
    end
  end

  assign stat_conflicts = conf_q;
  assign stat_forced    = forced_q;
`else
  assign stat_conflicts = 16'd0;
  assign stat_forced    = 16'd0;
`endif

endmodule
